// File: rtl/count8_loadable_pkg.sv
// Shared constants for the loadable up-counter: default width and reset value.
package count8_loadable_pkg;

    localparam int         CNT_WIDTH = 8;
    localparam logic [7:0] CNT_RESET = 8'h00;

endpackage

// File: rtl/count8_loadable.sv
// Synchronous up-counter with parallel load and count enable.
// Priority each rising edge: reset (active-low) > load > enable > hold.
module count8_loadable
    import count8_loadable_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic             load,
    input  logic [WIDTH-1:0] CNT_In,
    output logic [WIDTH-1:0] CNT
);

    logic [WIDTH-1:0] cnt_q;

    // Next value when not in reset; the increment wraps naturally at 2**WIDTH.
    function automatic logic [WIDTH-1:0] next_count(
        input logic             cur,
        input logic [WIDTH-1:0] cur_val,
        input logic             do_load,
        input logic [WIDTH-1:0] load_val
    );
        logic [WIDTH-1:0] nxt;
        nxt = cur_val;
        if (do_load) begin
            nxt = load_val;
        end else if (cur) begin
            nxt = cur_val + {{(WIDTH-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    always_ff @(posedge clk) begin
        if (!res) begin
            cnt_q <= WIDTH'(CNT_RESET);
        end else begin
            cnt_q <= next_count(EN, cnt_q, load, CNT_In);
        end
    end

    assign CNT = cnt_q;

endmodule

// File: tb/tb_count8_loadable.sv
// Self-checking bench for count8_loadable: directed scenarios, then random
// stimulus against an arithmetic reference model via an expected queue.
module tb_count8_loadable;

    logic       clk;
    logic       res;
    logic       EN;
    logic       load;
    logic [7:0] CNT_In;
    logic [7:0] CNT;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    int         model_cnt;

    count8_loadable dut (
        .clk    (clk),
        .res    (res),
        .EN     (EN),
        .load   (load),
        .CNT_In (CNT_In),
        .CNT    (CNT)
    );

    // Clock and reset-free start: inputs are driven from the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the counter value is an integer taken modulo 256.
    task automatic model_edge(input logic r, input logic l, input logic e, input logic [7:0] d);
        if (r == 1'b0)      model_cnt = 0;
        else if (l)         model_cnt = int'(d);
        else if (e)         model_cnt = (model_cnt + 1) % 256;
        exp_q.push_back(8'(model_cnt));
    endtask

    // Drive one cycle's inputs (called at a falling edge), clock one rising
    // edge, then compare at the next falling edge.
    task automatic step(input string tag, input logic r, input logic l,
                        input logic e, input logic [7:0] d);
        logic [7:0] exp;
        res = r; load = l; EN = e; CNT_In = d;
        model_edge(r, l, e, d);
        @(posedge clk);
        @(negedge clk);
        exp = exp_q.pop_front();
        check(tag, CNT, exp);
    endtask

    initial begin
        res = 1'b1; EN = 1'b0; load = 1'b0; CNT_In = 8'h00;
        model_cnt = 0;

        // Reset then count
        step("reset",       1'b0, 1'b0, 1'b1, 8'h00);
        step("count_01",    1'b1, 1'b0, 1'b1, 8'h00);
        step("count_02",    1'b1, 1'b0, 1'b1, 8'h00);
        step("count_03",    1'b1, 1'b0, 1'b1, 8'h00);
        check("const_03", CNT, 8'h03);

        // Load has priority over enable, and is tracked while held
        step("load_11a",    1'b1, 1'b1, 1'b1, 8'h11);
        step("load_11b",    1'b1, 1'b1, 1'b1, 8'h11);
        check("const_11", CNT, 8'h11);
        step("count_12",    1'b1, 1'b0, 1'b1, 8'h00);
        step("count_13",    1'b1, 1'b0, 1'b1, 8'h00);

        // Enable low holds
        for (int i = 0; i < 5; i++) step("hold_13", 1'b1, 1'b0, 1'b0, 8'h5A);
        check("const_13", CNT, 8'h13);
        step("count_14",    1'b1, 1'b0, 1'b1, 8'h00);

        // Wrap-around
        step("load_fe",     1'b1, 1'b1, 1'b0, 8'hFE);
        step("wrap_ff",     1'b1, 1'b0, 1'b1, 8'h00);
        step("wrap_00",     1'b1, 1'b0, 1'b1, 8'h00);
        check("const_00", CNT, 8'h00);
        step("wrap_01",     1'b1, 1'b0, 1'b1, 8'h00);

        // Reset beats load and enable, and holds at zero while asserted
        step("load_45",     1'b1, 1'b1, 1'b0, 8'h45);
        step("rst_prio",    1'b0, 1'b1, 1'b1, 8'hAA);
        step("rst_hold",    1'b0, 1'b0, 1'b1, 8'hAA);
        check("const_rst", CNT, 8'h00);
        step("rst_exit_01", 1'b1, 1'b0, 1'b1, 8'h00);

        // Load while disabled, then hold
        step("load_7c",     1'b1, 1'b1, 1'b0, 8'h7C);
        step("hold_7c",     1'b1, 1'b0, 1'b0, 8'h00);
        check("const_7c", CNT, 8'h7C);

        // Inputs changing after the edge must not reach CNT until the next edge
        @(posedge clk);
        #1;
        load = 1'b1; CNT_In = 8'h3C; EN = 1'b1;
        #2;
        check("no_comb_path", CNT, 8'h7C);
        @(negedge clk);
        load = 1'b0; EN = 1'b0;
        check("mid_cycle_edge", CNT, 8'h7C);

        // Randomized stimulus; reset and load kept rare so counting dominates
        for (int i = 0; i < 2000; i++) begin
            step("random",
                 ($urandom_range(0, 31) != 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) != 0),
                 8'($urandom_range(0, 255)));
        end

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL exp_q_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
